// File: rtl/keyboard_addr_if.sv
// ============================================================================
// keyboard_addr_if
// Bundles the key strobes, the current flash address and the controller
// outputs (state, idle, next address) between the keyboard decoder, the
// playback address controller and the flash-read address register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface keyboard_addr_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] currentaddr;
  logic              D;
  logic              E;
  logic              B;
  logic              F;
  logic              R;
  logic [1:0]        state;
  logic              idle;
  logic [ADDR_W-1:0] nextaddr;

  // Keyboard decoder / address register side
  modport master (
    output currentaddr, D, E, B, F, R,
    input  state, idle, nextaddr
  );

  // Playback address controller side
  modport slave (
    input  currentaddr, D, E, B, F, R,
    output state, idle, nextaddr
  );
endinterface

`default_nettype wire

// File: rtl/keyboard_addr.sv
// ============================================================================
// keyboard_addr
// Keyboard-driven playback address controller. Holds a run/direction state
// set by stop/start/backward/forward key levels and computes the next sample
// address (hold, increment, decrement, wrap or restart) from the current one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keyboard_addr #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(32'h0007_FFFF)
) (
  input  wire              clk,
  input  wire              reset_n,
  keyboard_addr_if.slave   bus
);

  // state[1] = run, state[0] = direction (1 = backward)
  typedef enum logic [1:0] {
    IDLE_FW = 2'b00,
    IDLE_BW = 2'b01,
    FW      = 2'b10,
    BW      = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] C_ZERO = '0;
  localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic              idle_q;
  logic              run_d;
  logic              dir_d;
  logic [ADDR_W-1:0] w_nextaddr;

  // Run and direction bits update independently; stop beats start,
  // and simultaneous backward+forward leaves direction unchanged.
  always_comb begin
    run_d = state_q[1];
    dir_d = state_q[0];
    if (bus.D) begin
      run_d = 1'b0;
    end else if (bus.E) begin
      run_d = 1'b1;
    end
    if (bus.B && !bus.F) begin
      dir_d = 1'b1;
    end else if (bus.F && !bus.B) begin
      dir_d = 1'b0;
    end
    state_d = state_t'({run_d, dir_d});
  end

  // State register with registered idle flag derived from the next run bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_FW;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= ~run_d;
    end
  end

  // Next address: restart wins, idle holds, run steps with wrap in [0, MAX_ADDR]
  always_comb begin
    w_nextaddr = bus.currentaddr;
    if (!reset_n) begin
      // While held in reset the address register just keeps its position.
      w_nextaddr = bus.currentaddr;
    end else if (bus.R) begin
      // Restart uses the registered direction, not pending B/F keys.
      w_nextaddr = state_q[0] ? MAX_ADDR : C_ZERO;
    end else begin
      case (state_q)
        FW: begin
          if (bus.currentaddr >= MAX_ADDR) begin
            w_nextaddr = C_ZERO;
          end else begin
            w_nextaddr = bus.currentaddr + C_ONE;
          end
        end
        BW: begin
          if ((bus.currentaddr == C_ZERO) || (bus.currentaddr > MAX_ADDR)) begin
            w_nextaddr = MAX_ADDR;
          end else begin
            w_nextaddr = bus.currentaddr - C_ONE;
          end
        end
        default: w_nextaddr = bus.currentaddr;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.idle     = idle_q;
  assign bus.nextaddr = w_nextaddr;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_addr.sv
// ============================================================================
// tb_keyboard_addr
// Directed and randomized checks of keyboard_addr against a behavioural
// model of the run/direction rules and the address stepping rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyboard_addr;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] MAXA   = 32'h0007_FFFF;

  logic clk;
  logic reset_n;

  int n_asserts;
  int n_fail;

  // Reference model state
  bit m_run;
  bit m_dir;

  keyboard_addr_if #(.ADDR_W(ADDR_W)) bus ();

  keyboard_addr #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAXA)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected next address from the playback rules
  function automatic logic [31:0] model_next(input logic [31:0] cur, input bit r);
    longint c;
    c = longint'(cur);
    if (!reset_n)          return cur;
    if (r)                 return m_dir ? MAXA : 32'd0;
    if (!m_run)            return cur;
    if (!m_dir) begin
      if (c >= longint'(MAXA)) return 32'd0;
      return 32'(c + 1);
    end
    if (c == 0 || c > longint'(MAXA)) return MAXA;
    return 32'(c - 1);
  endfunction

  task automatic check_all(input string tag);
    logic [1:0]  exp_state;
    logic        exp_idle;
    logic [31:0] exp_next;
    exp_state = {m_run, m_dir};
    exp_idle  = ~m_run;
    exp_next  = model_next(bus.currentaddr, bus.R);
    n_asserts++;
    assert (bus.state === exp_state) else begin
      n_fail++;
      $error("FAIL %s state: got %b expected %b", tag, bus.state, exp_state);
    end
    n_asserts++;
    assert (bus.idle === exp_idle) else begin
      n_fail++;
      $error("FAIL %s idle: got %b expected %b", tag, bus.idle, exp_idle);
    end
    n_asserts++;
    assert (bus.nextaddr === exp_next) else begin
      n_fail++;
      $error("FAIL %s nextaddr: got %h expected %h", tag, bus.nextaddr, exp_next);
    end
  endtask

  // Drive keys and address, clock once, update model, then check after the edge
  task automatic step(input bit d, input bit e, input bit b, input bit f,
                      input bit r, input logic [31:0] cur, input string tag);
    bus.D = d; bus.E = e; bus.B = b; bus.F = f; bus.R = r;
    bus.currentaddr = cur;
    @(posedge clk);
    if (d)            m_run = 1'b0;
    else if (e)       m_run = 1'b1;
    if (b && !f)      m_dir = 1'b1;
    else if (f && !b) m_dir = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    m_run     = 1'b0;
    m_dir     = 1'b0;
    reset_n   = 1'b0;
    bus.D = 1'b0; bus.E = 1'b0; bus.B = 1'b0; bus.F = 1'b0; bus.R = 1'b0;
    bus.currentaddr = 32'h100;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 reset_n = 1'b1;
    #1;
    check_all("reset_release");

    // Start forward, then restart while running
    step(0, 1, 0, 0, 0, 32'h100, "start_fw");
    step(0, 0, 0, 0, 1, 32'h100, "restart_fw");
    // Stop
    step(1, 0, 0, 0, 0, 32'h100, "stop");
    // Start backward in one clock
    step(0, 1, 1, 0, 0, 32'h100, "start_bw");
    bus.currentaddr = 32'h0;
    #1;
    check_all("bw_wrap_zero");
    step(0, 0, 0, 0, 0, 32'h0, "bw_hold");
    step(0, 0, 0, 0, 0, MAXA + 32'd1, "bw_above_max");
    // Forward wrap at MAX_ADDR and above
    step(0, 0, 0, 1, 0, MAXA, "fw_wrap_max");
    step(0, 0, 0, 0, 0, 32'hFFFF_FFFF, "fw_above_max");
    // D and E together from idleFW stays idle
    step(1, 0, 0, 0, 0, 32'h55, "stop2");
    step(1, 1, 0, 0, 0, 32'h55, "d_over_e");
    // B and F together leave direction unchanged
    step(0, 0, 1, 1, 0, 32'h55, "bf_hold");
    // Restart in BW
    step(0, 1, 1, 0, 0, 32'h200, "start_bw2");
    step(0, 0, 0, 0, 1, 32'h200, "restart_bw");
    // Restart while idle backward
    step(1, 0, 0, 0, 1, 32'h300, "restart_idle_bw");

    // Asynchronous reset mid-play
    step(0, 1, 0, 0, 0, 32'h400, "run_again");
    bus.R = 1'b0;
    #2 reset_n = 1'b0;
    m_run = 1'b0;
    m_dir = 1'b0;
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all("after_async_reset");

    // Randomized keys and addresses against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] cur;
      case ($urandom_range(0, 5))
        0:       cur = 32'd0;
        1:       cur = MAXA;
        2:       cur = MAXA + 32'd1;
        3:       cur = 32'd1;
        4:       cur = $urandom_range(0, 32'h7FFFF);
        default: cur = $urandom;
      endcase
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, cur, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
